// File: rtl/sys_timer_responder.sv
// Memory-mapped prescaled down-counter timer with auto-reload, sticky expiry flag and IRQ.
// Eight-word register window; reads return data one cycle after the strobe.
module sys_timer_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0100,
  parameter logic [31:0] ID_VALUE  = 32'hC0DE_7100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] sys_w_addr,
  input  logic [31:0] sys_r_addr,
  input  logic [31:0] sys_w_line,
  input  logic        sys_read,
  input  logic        sys_write,
  output logic [31:0] sys_r_line,
  output logic        sys_r_ack,
  output logic        irq
);

  localparam logic [2:0] OffCtrl   = 3'd0;
  localparam logic [2:0] OffPresc  = 3'd1;
  localparam logic [2:0] OffCount  = 3'd2;
  localparam logic [2:0] OffReload = 3'd3;
  localparam logic [2:0] OffStatus = 3'd4;
  localparam logic [2:0] OffId     = 3'd5;

  logic        r_en, r_ar, r_ie, r_exp;
  logic [15:0] r_presc, r_pcnt;
  logic [31:0] r_count, r_reload;

  logic        w_en_d, w_ar_d, w_ie_d, w_exp_d;
  logic [15:0] w_presc_d, w_pcnt_d;
  logic [31:0] w_count_d, w_reload_d;
  logic [31:0] w_rdata;
  logic        w_w_hit, w_r_hit, w_tick, w_expire, w_presc_wr;

  assign w_w_hit    = sys_write && (sys_w_addr[31:3] == BASE_ADDR[31:3]);
  assign w_r_hit    = sys_r_addr[31:3] == BASE_ADDR[31:3];
  assign w_tick     = r_en && (r_pcnt == r_presc);
  assign w_expire   = w_tick && (r_count == 32'd0);
  assign w_presc_wr = w_w_hit && (sys_w_addr[2:0] == OffPresc);
  assign irq        = r_exp & r_ie;

  // Tick effects first, bus writes override them, expiry set beats W1C.
  always_comb begin
    w_en_d     = r_en;
    w_ar_d     = r_ar;
    w_ie_d     = r_ie;
    w_presc_d  = r_presc;
    w_count_d  = r_count;
    w_reload_d = r_reload;
    w_exp_d    = r_exp;
    if (w_tick) begin
      if (r_count != 32'd0) begin
        w_count_d = r_count - 32'd1;
      end else if (r_ar) begin
        w_count_d = r_reload;
      end else begin
        w_en_d = 1'b0;
      end
    end
    if (w_w_hit) begin
      case (sys_w_addr[2:0])
        OffCtrl: begin
          w_en_d = sys_w_line[0];
          w_ar_d = sys_w_line[1];
          w_ie_d = sys_w_line[2];
        end
        OffPresc:  w_presc_d  = sys_w_line[15:0];
        OffCount:  w_count_d  = sys_w_line;
        OffReload: w_reload_d = sys_w_line;
        OffStatus: if (sys_w_line[0]) w_exp_d = 1'b0;
        default:   ;
      endcase
    end
    if (w_expire) w_exp_d = 1'b1;
  end

  // Prescaler restarts on enable, on disable, on a divisor change and on every tick.
  always_comb begin
    if (!r_en || !w_en_d || w_presc_wr || w_tick) begin
      w_pcnt_d = 16'd0;
    end else begin
      w_pcnt_d = r_pcnt + 16'd1;
    end
  end

  always_comb begin
    case (sys_r_addr[2:0])
      OffCtrl:   w_rdata = {29'd0, r_ie, r_ar, r_en};
      OffPresc:  w_rdata = {16'd0, r_presc};
      OffCount:  w_rdata = r_count;
      OffReload: w_rdata = r_reload;
      OffStatus: w_rdata = {31'd0, r_exp};
      OffId:     w_rdata = ID_VALUE;
      default:   w_rdata = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_en       <= 1'b0;
      r_ar       <= 1'b0;
      r_ie       <= 1'b0;
      r_exp      <= 1'b0;
      r_presc    <= 16'd0;
      r_pcnt     <= 16'd0;
      r_count    <= 32'd0;
      r_reload   <= 32'd0;
      sys_r_line <= 32'd0;
      sys_r_ack  <= 1'b0;
    end else begin
      r_en     <= w_en_d;
      r_ar     <= w_ar_d;
      r_ie     <= w_ie_d;
      r_exp    <= w_exp_d;
      r_presc  <= w_presc_d;
      r_pcnt   <= w_pcnt_d;
      r_count  <= w_count_d;
      r_reload <= w_reload_d;
      if (sys_read) begin
        sys_r_line <= w_r_hit ? w_rdata : 32'd0;
      end
      sys_r_ack <= sys_read && w_r_hit;
    end
  end

endmodule

// File: doc/sys_timer_responder.md
# sys_timer_responder

Memory-mapped timer peripheral on the CPU's system bus (`sys_*` port group). It receives the core's read and write strobes, decodes a fixed 8-word register window and returns read data with a registered one-cycle latency. Internally it holds a prescaled 32-bit down-counter with auto-reload, a sticky expiry flag and an interrupt request. It is the first responder the pipeline's `sys` memory path talks to.

## Interface
- `BASE_ADDR`, 32'h0000_0100, base of the register window; must be 8-aligned, `BASE_ADDR[2:0]` == 0.
- `ID_VALUE`, 32'hC0DE_7100, constant returned by the ID register.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: reset is synchronous and active-high.
- `sys_w_addr` in 32: write address.
- `sys_r_addr` in 32: read address.
- `sys_w_line` in 32: write data.
- `sys_read` in 1: read strobe, one access per cycle.
- `sys_write` in 1: write strobe, one access per cycle.
- `sys_r_line` out 32: read data, registered.
- `sys_r_ack` out 1: read hit in window, registered and aligned with `sys_r_line`.
- `irq` out 1: interrupt request, equal to `EXP & IE`.

## Operation
- Decode: an access hits when `addr[31:3] == BASE_ADDR[31:3]`. The offset is `addr[2:0]`, one word per offset.
- Register map:
  - 0 CTRL: bit0 EN, bit1 AR (auto-reload), bit2 IE. Other bits read 0.
  - 1 PRESC: bits[15:0] prescaler divisor. Upper bits read 0.
  - 2 COUNT: current counter value. Writable.
  - 3 RELOAD: reload value.
  - 4 STATUS: bit0 EXP. Write-1-to-clear.
  - 5 ID: read-only `ID_VALUE`.
  - 6, 7: reserved. Read 0, writes ignored.
- Prescaler: internal 16-bit `pcnt`.
  - While EN=1: if `pcnt == PRESC`, then `pcnt` <= 0 and assert internal `tick`; otherwise `pcnt` increments.
  - While EN=0: `pcnt` holds 0.
- On `tick`:
  - If COUNT != 0: COUNT <= COUNT-1.
  - If COUNT == 0: expire event. EXP <= 1. If AR=1, COUNT <= RELOAD. If AR=0, EN <= 0 and COUNT stays 0.
- Period with AR=1 is `(RELOAD+1)*(PRESC+1)` cycles.
- Writes (`sys_write`=1 and hit): update the addressed register at the edge. A write with no hit is ignored.
- Reads (`sys_read`=1):
  - Hit: `sys_r_line` <= register value before any same-edge update, and `sys_r_ack` <= 1.
  - Miss: `sys_r_line` <= 0 and `sys_r_ack` <= 0.
  - `sys_read`=0: `sys_r_line` holds its last value and `sys_r_ack` <= 0.
- A read and a write in the same cycle are both serviced. A read of the register being written returns the old value.
- Simultaneous events:
  - Bus write to COUNT in the same cycle as a tick: the write wins.
  - Bus write to CTRL with EN=0 in the same cycle as an expire event: the write's EN wins. EXP is still set.
  - STATUS write-1 in the same cycle as an expire event: EXP stays 1 (set wins).
  - Write to PRESC: `pcnt` <= 0 at the same edge.
  - EN transition 0→1 by write: `pcnt` <= 0 at the same edge.

## Timing
- Reset values: `sys_r_line`=0, `sys_r_ack`=0, `irq`=0; CTRL, PRESC, COUNT, RELOAD, EXP and `pcnt` all 0.
- Assertion of `rst` mid-count clears all state at that edge. Bus accesses during reset are dropped.
- Read latency: `sys_r_line` and `sys_r_ack` are valid the cycle after `sys_read` is sampled. Back-to-back reads give one result per cycle.
- Write latency: the register holds the new value after the sampling edge and is visible to a read issued the next cycle.
- Tick timing: a write setting EN at edge N gives the first tick at edge N+1 when PRESC=0, or at edge N+PRESC+1 in general.
- `irq` is combinational from registered EXP and IE, so it rises the cycle after the expire edge. It has no glitch path from bus inputs.

## Test plan
- Reset: hold `rst` for 2 cycles, then read offsets 0–5 → all 0 except ID = 32'hC0DE_7100; `sys_r_ack`=1 one cycle after each read.
- Auto-reload, PRESC=0: write RELOAD=3, COUNT=3, then CTRL=7 at edge N → COUNT reads 2, 1, 0 after edges N+1..N+3. EXP=1, COUNT=3 and `irq`=1 after edge N+4. Next expire at N+8.
- One-shot, PRESC=2: COUNT=1, CTRL=1 → expire at edge N+6. After it, EN=0, COUNT=0, EXP=1, and `irq`=0 because IE=0.
- W1C race: arrange a STATUS write of 1 on the expire edge → EXP remains 1. A STATUS write of 1 on a later cycle → EXP=0 and `irq` falls the next cycle.
- Window decode: read BASE_ADDR+8 and BASE_ADDR-1 → `sys_r_line`=0, `sys_r_ack`=0. A write to BASE_ADDR+8 with data 5 leaves CTRL at 0.
- Same-cycle access: read COUNT while writing COUNT=32'hDEAD_BEEF → read returns the old value; a read the next cycle returns DEAD_BEEF. A tick on the write edge does not decrement it.
